serial_adder_seq: RTL and testbench
===================================

Name: serial_adder_seq

Overview:
- Bit-serial adder that computes S = A + B + Cin over WIDTH clock cycles, one bit per cycle, using a single full-adder cell plus a carry flip-flop.
- It sits around the exp7 full-adder cell. It feeds that cell's A, B and Cin one bit per cycle, and consumes its S and Cout.
- It gives the lab a sequential, handshaked multi-bit adder built from the verified 1-bit cell.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on the accepted start.
- B  input  WIDTH  operand B; captured on the accepted start.
- Cin  input  1  carry-in; captured on the accepted start.
- busy  output  1  high while an addition is in progress (SHIFT state).
- done  output  1  one-cycle pulse; the result is valid from this cycle onwards.
- S  output  WIDTH  sum result, registered.
- Cout  output  1  final carry-out, registered.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, S=0, Cout=0.
  - Operand shift registers, carry register and bit counter cleared.
  - Takes effect immediately, including mid-operation; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0; S and Cout hold the previous result.
  - start=1 at a rising edge: areg<=A, breg<=B, carry<=Cin, cnt<=0, sreg<=0; next state SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1), at each rising edge:
  - sum_bit = areg[0]^breg[0]^carry.
  - carry <= (areg[0]&breg[0]) | (carry&(areg[0]^breg[0])).
  - sreg <= {sum_bit, sreg[WIDTH-1:1]}; areg and breg shift right by 1.
  - cnt <= cnt+1.
  - At the edge where cnt==WIDTH-1 (last bit): also S <= final shifted sreg, Cout <= new carry; next state DONE.
- DONE:
  - done=1, busy=0 for exactly one cycle.
  - Next edge: return to IDLE unconditionally.
  - start is ignored in DONE; it must be reasserted in IDLE.
- Latency:
  - start accepted at edge 0; bits processed at edges 1..WIDTH.
  - done high during the cycle after edge WIDTH.
  - Earliest next start is accepted at edge WIDTH+2.
- Handshake and output stability:
  - start while busy or done is ignored; no restart, no queuing.
  - Operand changes after acceptance have no effect.
  - S and Cout change only on the final SHIFT edge or on reset; they are stable in IDLE and DONE.
- Counter width: clog2(WIDTH)+1 bits; wrap-around is never reached.
- WIDTH=1:
  - One SHIFT cycle.
  - Result must equal the 1-bit full-adder truth table for all 8 {A,B,Cin} combinations.
- Overflow: the result is the modulo-2^WIDTH sum; the overflow bit appears on Cout.
  - Cout=1 when A+B+Cin >= 2^WIDTH.

Test Plan:
- WIDTH=8: A=8'h00, B=8'h00, Cin=0, start one cycle -> busy high 8 cycles; done pulse 1 cycle; S=8'h00, Cout=0.
- WIDTH=8: A=8'h3C, B=8'h0F, Cin=0 -> S=8'h4B, Cout=0.
- WIDTH=8: A=8'hFF, B=8'h01, Cin=0 -> S=8'h00, Cout=1.
- WIDTH=8: A=8'hA5, B=8'h5A, Cin=1 -> S=8'h00, Cout=1.
- Next, with the previous result S=8'h00, Cout=1 still held:
  - A=8'h12, B=8'h34 started; start pulsed again at cycle 3 with A=8'hFF -> second start ignored.
  - Required: S=8'h46, Cout=0; done pulses once; done arrives 9 cycles after the accepted start edge.
- WIDTH=8: start A=8'hFF, B=8'hFF, Cin=1; drop rst_n low in cycle 4 of SHIFT:
  - Immediately busy=0, done=0, S=8'h00, Cout=0, state IDLE.
  - After rst_n release, a fresh start A=8'h01, B=8'h01, Cin=0 -> S=8'h02, Cout=0.
- Separate instance WIDTH=1: sweep all 8 {A,B,Cin} from 000 to 111:
  - Required {Cout,S} = 00, 01, 01, 10, 01, 10, 10, 11.
  - Each result follows done after 1 SHIFT cycle.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: S = A + B + Cin computed LSB-first over WIDTH cycles
// with one full-adder cell and a carry flip-flop, behind a start/done handshake.
module serial_adder_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state;
  logic [WIDTH-1:0] areg, breg, sreg, sreg_next;
  logic            carry, sum_bit, carry_next;
  logic [CntW-1:0] cnt;

  // Full-adder cell on the current LSBs
  assign sum_bit    = areg[0] ^ breg[0] ^ carry;
  assign carry_next = (areg[0] & breg[0]) | (carry & (areg[0] ^ breg[0]));

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts
  if (WIDTH == 1) begin : g_w1
    assign sreg_next = sum_bit;
  end else begin : g_wn
    assign sreg_next = {sum_bit, sreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= StIdle;
      areg  <= '0;
      breg  <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      Cout  <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            areg  <= A;
            breg  <= B;
            carry <= Cin;
            cnt   <= '0;
            sreg  <= '0;
            busy  <= 1'b1;
            state <= StShift;
          end
        end
        StShift: begin
          carry <= carry_next;
          sreg  <= sreg_next;
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH - 1)) begin
            S     <= sreg_next;
            Cout  <= carry_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end
        end
        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: WIDTH=8 vectors, ignored restart,
// mid-operation reset, and a WIDTH=1 truth-table sweep.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] s8;

  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, s1, cout1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] prev_s;
  logic       prev_c;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_adder_seq #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Start an 8-bit add; glitch_cyc>0 re-pulses start with A=FF in that busy cycle.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic ci, input logic [7:0] es, input logic ec,
                      input int glitch_cyc);
    int cyc, busy_cnt, extra_done;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1; busy_cnt = 0;
    while (!done8 && cyc < 40) begin
      if (busy8) busy_cnt++;
      if (cyc == 4) check({tag, "_s_hold"}, {23'd0, prev_c, prev_s}, {23'd0, cout8, s8});
      if (glitch_cyc != 0 && cyc == glitch_cyc) begin
        start8 = 1'b1; a8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start8 = 1'b0;
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_busy_in_done"}, busy8, 1'b0);
    check({tag, "_S"}, s8, es);
    check({tag, "_Cout"}, cout8, ec);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) extra_done++;
    end
    check({tag, "_done_once"}, extra_done, 0);
    check({tag, "_S_stable"}, {cout8, s8}, {ec, es});
    prev_s = es; prev_c = ec;
  endtask

  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    prev_s = 8'h00; prev_c = 1'b0;
    #12;
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_S8", s8, 8'h00);
    check("rst_Cout8", cout8, 1'b0);
    check("rst_w1", {busy1, done1, cout1, s1}, 4'b0000);
    @(negedge clk); rst_n = 1'b1;

    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0);
    run8("v3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 0);
    run8("vff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
    run8("va55a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 0);
    run8("ignore", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);

    // Mid-operation reset: start FF+FF+1, reset in the 4th busy cycle
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_before_rst", busy8, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 1'b0);
    check("mid_rst_done", done8, 1'b0);
    check("mid_rst_S", s8, 8'h00);
    check("mid_rst_Cout", cout8, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    prev_s = 8'h00; prev_c = 1'b0;
    run8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

    // WIDTH=1 truth table
    for (int v = 0; v < 8; v++) begin
      int cyc;
      logic [2:0] vec;
      vec = 3'(v);
      @(negedge clk);
      a1 = vec[2]; b1 = vec[1]; cin1 = vec[0]; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      cyc = 1;
      while (!done1 && cyc < 10) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("w1_latency_%0d", v), cyc, 2);
      check($sformatf("w1_sum_%0d", v), {cout1, s1}, tt[v]);
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
